// File: rtl/pc_pkg.sv
// Shared types and helpers for the IF-stage program-counter generator.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package pc_pkg;

  typedef enum logic {
    PC_IDLE = 1'b0,
    PC_RUN  = 1'b1
  } pc_state_t;

  typedef enum logic [1:0] {
    SEL_HOLD  = 2'd0,
    SEL_REDIR = 2'd1,
    SEL_PEND  = 2'd2,
    SEL_INC   = 2'd3
  } pc_sel_t;

  // Mask with the low 'bits' positions cleared; bits = 0 yields all ones.
  function automatic logic [63:0] align_mask(input int unsigned bits);
    logic [63:0] m;
    m = '1;
    m = m << bits;
    return m;
  endfunction

endpackage

// File: rtl/pc_redirect_buf.sv
// One-entry pending-redirect buffer: keeps a branch/jump target raised while the PC is held.
// Latency: load/clear take effect on the next clk_i edge; aligned_o is combinational from target_i.
// Backpressure: none; a newer load overwrites the stored target, load wins over clear.
module pc_redirect_buf
  import pc_pkg::*;
#(
  parameter int unsigned PC_WIDTH   = 32,
  parameter int unsigned ALIGN_BITS = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                load_i,
  input  logic                clear_i,
  input  logic [PC_WIDTH-1:0] target_i,
  output logic [PC_WIDTH-1:0] aligned_o,
  output logic                pend_valid_o,
  output logic [PC_WIDTH-1:0] pend_pc_o
);

  localparam logic [PC_WIDTH-1:0] MASK = PC_WIDTH'(align_mask(ALIGN_BITS));

  logic [PC_WIDTH-1:0] w_aligned;
  logic                r_valid;
  logic [PC_WIDTH-1:0] r_pc;

  assign w_aligned = target_i & MASK;

  // Capture the aligned target on load; drop the valid flag once it is consumed.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
    end else if (load_i) begin
      r_valid <= 1'b1;
      r_pc    <= w_aligned;
    end else if (clear_i) begin
      r_valid <= 1'b0;
    end
  end

  assign aligned_o    = w_aligned;
  assign pend_valid_o = r_valid;
  assign pend_pc_o    = r_pc;

endmodule

// File: rtl/pc_unit.sv
// IF-stage program counter: sequential increment, stall/hold arbitration, buffered redirects.
// Latency: pc_o updates one edge after an unblocked cycle; all outputs are register-driven.
// Backpressure: stall_i, then pc_write_i = 0, hold pc_o; redirects seen while held are buffered.
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned         PC_WIDTH     = 32,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int unsigned         INC          = 4,
  parameter int unsigned         ALIGN_BITS   = 2,
  parameter int unsigned         CNT_WIDTH    = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 stall_i,
  input  logic                 pc_write_i,
  input  logic                 redirect_i,
  input  logic [PC_WIDTH-1:0]  redirect_pc_i,
  output logic [PC_WIDTH-1:0]  pc_o,
  output logic                 pc_valid_o,
  output logic                 pend_valid_o,
  output logic [CNT_WIDTH-1:0] fetch_cnt_o
);

  pc_state_t           r_state;
  pc_state_t           w_state_nxt;
  pc_sel_t             w_sel;
  logic                w_buf_load;
  logic                w_buf_clear;
  logic [PC_WIDTH-1:0] w_aligned;
  logic                w_pend_valid;
  logic [PC_WIDTH-1:0] w_pend_pc;
  logic [PC_WIDTH-1:0] r_pc;
  logic [CNT_WIDTH-1:0] r_cnt;

  pc_redirect_buf #(
    .PC_WIDTH   (PC_WIDTH),
    .ALIGN_BITS (ALIGN_BITS)
  ) u_redirect_buf (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .load_i       (w_buf_load),
    .clear_i      (w_buf_clear),
    .target_i     (redirect_pc_i),
    .aligned_o    (w_aligned),
    .pend_valid_o (w_pend_valid),
    .pend_pc_o    (w_pend_pc)
  );

  // Run/idle state register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= PC_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and next-PC select; any edge that does not advance buffers a redirect.
  always_comb begin
    w_state_nxt = r_state;
    w_sel       = SEL_HOLD;
    w_buf_load  = 1'b0;
    w_buf_clear = 1'b0;
    case (r_state)
      PC_IDLE: begin
        // The PC is not moved on the start edge: first fetch uses the current pc_o.
        if (start_i) w_state_nxt = PC_RUN;
        w_buf_load = redirect_i;
      end
      PC_RUN: begin
        if (!start_i) begin
          w_state_nxt = PC_IDLE;
          w_buf_load  = redirect_i;
        end else if (stall_i || !pc_write_i) begin
          w_buf_load = redirect_i;
        end else if (redirect_i) begin
          // A live redirect supersedes any older buffered target.
          w_sel       = SEL_REDIR;
          w_buf_clear = 1'b1;
        end else if (w_pend_valid) begin
          w_sel       = SEL_PEND;
          w_buf_clear = 1'b1;
        end else begin
          w_sel = SEL_INC;
        end
      end
      default: w_state_nxt = PC_IDLE;
    endcase
  end

  // PC register; the increment wraps modulo 2^PC_WIDTH.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_pc <= RESET_VECTOR;
    end else begin
      case (w_sel)
        SEL_REDIR: r_pc <= w_aligned;
        SEL_PEND:  r_pc <= w_pend_pc;
        SEL_INC:   r_pc <= r_pc + PC_WIDTH'(INC);
        default:   r_pc <= r_pc;
      endcase
    end
  end

  // Saturating count of PC updates.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_cnt <= '0;
    end else if ((w_sel != SEL_HOLD) && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_WIDTH'(1);
    end
  end

  assign pc_o         = r_pc;
  assign pc_valid_o   = (r_state == PC_RUN);
  assign pend_valid_o = w_pend_valid;
  assign fetch_cnt_o  = r_cnt;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: default-parameter instance plus a narrow 8-bit/4-bit instance.
// Expected output tuples are queued as each step is driven and popped after the edge.
// Outputs are sampled 1 time unit after the rising edge.
module tb_pc_unit;

  typedef struct packed {
    logic [31:0] pc;
    logic        vld;
    logic        pend;
    logic [31:0] cnt;
  } exp_t;

  logic clk;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  // Instance A: default parameters.
  logic        a_rst, a_start, a_stall, a_pw, a_redir;
  logic [31:0] a_rpc, a_pc, a_cnt;
  logic        a_vld, a_pend;

  // Instance B: PC_WIDTH = 8, CNT_WIDTH = 4.
  logic        b_rst, b_start, b_stall, b_pw, b_redir;
  logic [7:0]  b_rpc, b_pc;
  logic [3:0]  b_cnt;
  logic        b_vld, b_pend;

  pc_unit u_dut_a (
    .clk_i         (clk),
    .rst_i         (a_rst),
    .start_i       (a_start),
    .stall_i       (a_stall),
    .pc_write_i    (a_pw),
    .redirect_i    (a_redir),
    .redirect_pc_i (a_rpc),
    .pc_o          (a_pc),
    .pc_valid_o    (a_vld),
    .pend_valid_o  (a_pend),
    .fetch_cnt_o   (a_cnt)
  );

  pc_unit #(
    .PC_WIDTH  (8),
    .CNT_WIDTH (4)
  ) u_dut_b (
    .clk_i         (clk),
    .rst_i         (b_rst),
    .start_i       (b_start),
    .stall_i       (b_stall),
    .pc_write_i    (b_pw),
    .redirect_i    (b_redir),
    .redirect_pc_i (b_rpc),
    .pc_o          (b_pc),
    .pc_valid_o    (b_vld),
    .pend_valid_o  (b_pend),
    .fetch_cnt_o   (b_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic push(input logic [31:0] pc, input logic vld, input logic pend, input logic [31:0] cnt);
    exp_t e;
    e.pc = pc; e.vld = vld; e.pend = pend; e.cnt = cnt;
    q.push_back(e);
  endtask

  task automatic compare(input string tag, input exp_t o);
    exp_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $error("FAIL %s: scoreboard empty, observed pc=%h expected an entry", tag, o.pc);
    end else begin
      e = q.pop_front();
      assert (o === e) else begin
        errors++;
        $error("FAIL %s: observed pc=%h vld=%b pend=%b cnt=%0d, expected pc=%h vld=%b pend=%b cnt=%0d",
               tag, o.pc, o.vld, o.pend, o.cnt, e.pc, e.vld, e.pend, e.cnt);
      end
    end
  endtask

  task automatic cmp_a(input string tag);
    compare(tag, {a_pc, a_vld, a_pend, a_cnt});
  endtask

  task automatic cmp_b(input string tag);
    compare(tag, {24'd0, b_pc, b_vld, b_pend, 28'd0, b_cnt});
  endtask

  // Drive one cycle of stimulus on A, queue the expected post-edge outputs, then compare.
  task automatic step_a(input logic st, input logic sp, input logic pw, input logic rd,
                        input logic [31:0] rpc, input logic [31:0] epc, input logic ev,
                        input logic ep, input logic [31:0] ec, input string tag);
    a_start = st; a_stall = sp; a_pw = pw; a_redir = rd; a_rpc = rpc;
    push(epc, ev, ep, ec);
    @(posedge clk);
    #1;
    cmp_a(tag);
  endtask

  task automatic step_b(input logic rd, input logic [7:0] rpc, input logic [7:0] epc,
                        input logic [3:0] ec, input string tag);
    b_start = 1'b1; b_stall = 1'b0; b_pw = 1'b1; b_redir = rd; b_rpc = rpc;
    push({24'd0, epc}, 1'b1, 1'b0, {28'd0, ec});
    @(posedge clk);
    #1;
    cmp_b(tag);
  endtask

  initial begin
    a_rst = 1'b0; a_start = 1'b0; a_stall = 1'b0; a_pw = 1'b1; a_redir = 1'b0; a_rpc = '0;
    b_rst = 1'b0; b_start = 1'b0; b_stall = 1'b0; b_pw = 1'b1; b_redir = 1'b0; b_rpc = '0;
    #2;
    push(32'h0, 1'b0, 1'b0, 32'd0);
    cmp_a("reset_state");
    #10;
    a_rst = 1'b1;
    b_rst = 1'b1;
    @(posedge clk);
    #1;

    //     start stall pw redir rpc         exp_pc   vld   pend  cnt
    step_a(1'b1, 1'b0, 1'b1, 1'b0, 32'h0,   32'h000, 1'b1, 1'b0, 32'd0,  "start_first_fetch");
    step_a(1'b1, 1'b0, 1'b1, 1'b0, 32'h0,   32'h004, 1'b1, 1'b0, 32'd1,  "inc_4");
    step_a(1'b1, 1'b0, 1'b1, 1'b0, 32'h0,   32'h008, 1'b1, 1'b0, 32'd2,  "inc_8");
    step_a(1'b1, 1'b0, 1'b1, 1'b0, 32'h0,   32'h00C, 1'b1, 1'b0, 32'd3,  "inc_12_cnt3");
    step_a(1'b1, 1'b0, 1'b1, 1'b0, 32'h0,   32'h010, 1'b1, 1'b0, 32'd4,  "inc_16");
    // Redirect raised mid-stall is buffered and released after the stall.
    step_a(1'b1, 1'b1, 1'b1, 1'b0, 32'h0,   32'h010, 1'b1, 1'b0, 32'd4,  "stall_1");
    step_a(1'b1, 1'b1, 1'b1, 1'b1, 32'h203, 32'h010, 1'b1, 1'b1, 32'd4,  "stall_2_redir");
    step_a(1'b1, 1'b1, 1'b1, 1'b0, 32'h0,   32'h010, 1'b1, 1'b1, 32'd4,  "stall_3_hold");
    step_a(1'b1, 1'b0, 1'b1, 1'b0, 32'h0,   32'h200, 1'b1, 1'b0, 32'd5,  "stall_release_pend");
    step_a(1'b1, 1'b0, 1'b1, 1'b0, 32'h0,   32'h204, 1'b1, 1'b0, 32'd6,  "after_pend_inc");
    // Newer buffered redirect overwrites the older one.
    step_a(1'b1, 1'b1, 1'b1, 1'b1, 32'h100, 32'h204, 1'b1, 1'b1, 32'd6,  "overwrite_first");
    step_a(1'b1, 1'b1, 1'b1, 1'b1, 32'h300, 32'h204, 1'b1, 1'b1, 32'd6,  "overwrite_second");
    step_a(1'b1, 1'b0, 1'b1, 1'b0, 32'h0,   32'h300, 1'b1, 1'b0, 32'd7,  "overwrite_release");
    // Live redirect supersedes a pending one and clears the buffer.
    step_a(1'b1, 1'b1, 1'b1, 1'b1, 32'h100, 32'h300, 1'b1, 1'b1, 32'd7,  "supersede_pend");
    step_a(1'b1, 1'b0, 1'b1, 1'b1, 32'h400, 32'h400, 1'b1, 1'b0, 32'd8,  "supersede_live");
    step_a(1'b1, 1'b0, 1'b1, 1'b0, 32'h0,   32'h404, 1'b1, 1'b0, 32'd9,  "supersede_discarded");
    // Hazard hold wins over a simultaneous redirect.
    step_a(1'b1, 1'b0, 1'b0, 1'b1, 32'h80,  32'h404, 1'b1, 1'b1, 32'd9,  "hazard_hold_redir");
    step_a(1'b1, 1'b0, 1'b1, 1'b0, 32'h0,   32'h080, 1'b1, 1'b0, 32'd10, "hazard_release");
    // Low target bits are forced to zero.
    step_a(1'b1, 1'b0, 1'b1, 1'b1, 32'h87,  32'h084, 1'b1, 1'b0, 32'd11, "align_target");
    // Stop, buffer in IDLE, restart without moving the PC on the start edge.
    step_a(1'b0, 1'b0, 1'b1, 1'b0, 32'h0,   32'h084, 1'b0, 1'b0, 32'd11, "run_to_idle");
    step_a(1'b0, 1'b0, 1'b1, 1'b1, 32'h500, 32'h084, 1'b0, 1'b1, 32'd11, "idle_redir_buffered");
    step_a(1'b1, 1'b0, 1'b1, 1'b0, 32'h0,   32'h084, 1'b1, 1'b1, 32'd11, "idle_to_run");
    step_a(1'b1, 1'b0, 1'b1, 1'b0, 32'h0,   32'h500, 1'b1, 1'b0, 32'd12, "idle_pend_released");
    // Asynchronous reset mid-stall with a redirect pending.
    step_a(1'b1, 1'b1, 1'b1, 1'b1, 32'h600, 32'h500, 1'b1, 1'b1, 32'd12, "pre_reset_pend");
    a_redir = 1'b0;
    #2;
    a_rst = 1'b0;
    #1;
    push(32'h0, 1'b0, 1'b0, 32'd0);
    cmp_a("async_reset_immediate");
    #3;
    a_rst = 1'b1;
    a_start = 1'b0;
    @(posedge clk);
    #1;
    push(32'h0, 1'b0, 1'b0, 32'd0);
    cmp_a("post_reset_idle");

    // Narrow instance: wrap of the PC and saturation of the counter.
    b_start = 1'b1;
    push(32'h0, 1'b1, 1'b0, 32'd0);
    @(posedge clk);
    #1;
    cmp_b("b_start");
    step_b(1'b1, 8'hFC, 8'hFC, 4'd1, "b_redir_fc");
    step_b(1'b0, 8'h00, 8'h00, 4'd2, "b_wrap_00");
    for (int i = 0; i < 18; i++) begin
      step_b(1'b0, 8'h00, 8'((i + 1) * 4), 4'((i + 3 > 15) ? 15 : i + 3), "b_advance");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
Parametrised program-counter generator for the pipelined core's IF stage. It computes the sequential increment internally and arbitrates stalls from the memory/cache system, holds from the hazard unit, and branch/jump redirects. A one-entry redirect buffer ensures a redirect raised during a hold or stall is never lost. It also exposes a run/idle state and a fetch-advance counter for performance checks.

Parameters:
PC_WIDTH, 32, width of the PC and redirect target
RESET_VECTOR, 0, PC value after reset
INC, 4, sequential increment added per advance
ALIGN_BITS, 2, number of low redirect-target bits forced to 0
CNT_WIDTH, 32, width of the fetch-advance counter

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous, active-low reset
start_i  in  1  run enable; 0 freezes the PC
stall_i  in  1  memory/cache stall; highest-priority hold
pc_write_i  in  1  hazard unit write enable; 0 = load-use hold
redirect_i  in  1  branch/jump taken this cycle
redirect_pc_i  in  PC_WIDTH  redirect target
pc_o  out  PC_WIDTH  current fetch address (registered)
pc_valid_o  out  1  1 when state = RUN (registered)
pend_valid_o  out  1  redirect buffer occupied
fetch_cnt_o  out  CNT_WIDTH  number of PC updates since reset

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is asynchronous and active-low.
- Reset (any time, including mid-stall or with a redirect pending):
  - pc_o = RESET_VECTOR
  - state = IDLE, pc_valid_o = 0
  - pend_valid_o = 0, pending PC = 0
  - fetch_cnt_o = 0
- States:
  - IDLE -> RUN on a clock edge with start_i = 1. pc_o does not change on that edge, so the first fetch is at the current pc_o.
  - RUN -> IDLE on a clock edge with start_i = 0. pc_o holds its current value and is not reset to RESET_VECTOR.
- IDLE: pc_o holds. A redirect_i is captured into the buffer.
- RUN next-PC priority (evaluated each edge):
  1. stall_i = 1: pc_o holds. If redirect_i, the pending PC is loaded with the aligned target and pend_valid_o = 1. A newer redirect overwrites an older pending one.
  2. pc_write_i = 0: same as case 1. The hold wins over a simultaneous redirect; the redirect is buffered.
  3. redirect_i = 1: pc_o = aligned redirect_pc_i. The buffer is cleared, discarding any older pending target.
  4. pend_valid_o = 1: pc_o = pending PC; the buffer is cleared.
  5. Otherwise: pc_o = pc_o + INC, truncated modulo 2^PC_WIDTH (wraps, no flag).
- Aligned target = redirect_pc_i with bits [ALIGN_BITS-1:0] forced to 0. When ALIGN_BITS = 0, the target is used unmodified.
- fetch_cnt_o increments by 1 on every edge where cases 3, 4 or 5 apply. It saturates at all-ones and does not wrap.
- Latency: a redirect in an unblocked RUN cycle appears on pc_o one cycle later. A buffered redirect appears one cycle after the first edge with stall_i = 0, pc_write_i = 1 and start_i = 1.
- No combinational path from any input to any output.

Decomposition:
- Shared package pc_pkg holds:
  - the state enum {PC_IDLE, PC_RUN}
  - the next-PC select encoding {SEL_HOLD, SEL_REDIR, SEL_PEND, SEL_INC}
  - an align-mask helper function
- One natural sub-module, pc_redirect_buf: the pending-target register with its valid flag, load/overwrite/clear controls and alignment.
- Next-PC mux, state register and counter stay in pc_unit.

Test Plan:
1. Reset then start (defaults): start_i = 1 at cycle 1 -> pc_valid_o = 1 with pc_o = 0 at cycle 2, then 4, 8, 12 on successive cycles; fetch_cnt_o = 3 after three advances.
2. Redirect during stall: pc_o = 0x10, stall_i = 1 for 3 cycles, redirect_i with 0x203 in stall cycle 2 -> pc_o stays 0x10 and pend_valid_o = 1. The first cycle after the stall gives pc_o = 0x200, then 0x204; pend_valid_o = 0.
3. Overwrite and supersede: two redirects (0x100, then 0x300) during a stall -> pc_o = 0x300 after release. Separately, pending 0x100 plus a live redirect 0x400 in an unblocked cycle -> pc_o = 0x400 and the buffer clears.
4. Hazard hold with redirect: pc_write_i = 0 with redirect_i (0x80) in the same cycle -> pc_o holds and pend_valid_o = 1. Next unblocked cycle gives pc_o = 0x80.
5. Wrap and saturate: PC_WIDTH = 8, pc_o = 0xFC -> next pc_o = 0x00. CNT_WIDTH = 4 after 20 advances -> fetch_cnt_o = 0xF.
6. Mid-operation reset: assert rst_i low asynchronously with a redirect pending and stall_i = 1 -> outputs return to reset values immediately, without waiting for a clock edge; state = IDLE.
